// File: rtl/tdm_demux.sv
// tdm_demux: receive end of a serial TDM link; splits a 1-bit stream into NCH words of W bits.
// Latency: a channel word and its ch_valid pulse appear 1 clk after the slot's last bit is sampled.
// Backpressure: none; en=0 stalls every counter and register, pulse outputs drop to 0.
//
// Ports: clk/rst_n (async active-low), en (bit enable), din (serial data, MSB first),
//        fs (frame sync on bit 0 of slot 0), ch_data (slot k at [k*W +: W]), ch_valid (per-slot pulse),
//        frame_done (with ch_valid[NCH-1]), sync_err (sync violation pulse),
//        par_err (per-slot parity error pulse), locked (high while running).
// Optional: define TDM_DEMUX_PARITY_EN to expect one even-parity bit after each slot's data bits;
//           left undefined, slots are W bits long and par_err is tied to 0.
module tdm_demux #(
   parameter int NCH = 4,
   parameter int W   = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             din,
   input  logic             fs,
   output logic [NCH*W-1:0] ch_data,
   output logic [NCH-1:0]   ch_valid,
   output logic             frame_done,
   output logic             sync_err,
   output logic [NCH-1:0]   par_err,
   output logic             locked
);

   localparam int CW = $clog2(NCH);
   localparam int BW = $clog2(W + 1);
`ifdef TDM_DEMUX_PARITY_EN
   localparam int L = W + 1;
`else
   localparam int L = W;
`endif

   typedef enum logic {HUNT, RUN} state_e;

   state_e           state_q, state_d;
   logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
   logic [CW-1:0]    slot_cnt_q, slot_cnt_d;
   logic [W-1:0]     sh_q, sh_d;
   logic [NCH*W-1:0] ch_data_q, ch_data_d;
   logic [NCH-1:0]   ch_valid_q, ch_valid_d;
   logic             frame_done_q, frame_done_d;
   logic             sync_err_q, sync_err_d;
   logic             locked_q, locked_d;
`ifdef TDM_DEMUX_PARITY_EN
   logic             par_q, par_d;
   logic [NCH-1:0]   par_err_q, par_err_d;
`endif

   logic frame_start;
   logic bit_last;
   logic slot_last;

   // Counters at zero while running means the next bit must be bit 0 of slot 0.
   assign frame_start = (bit_cnt_q == '0) && (slot_cnt_q == '0);
   assign bit_last    = (bit_cnt_q == BW'(L - 1));
   assign slot_last   = (slot_cnt_q == CW'(NCH - 1));

   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      slot_cnt_d   = slot_cnt_q;
      sh_d         = sh_q;
      ch_data_d    = ch_data_q;
      ch_valid_d   = '0;
      frame_done_d = 1'b0;
      sync_err_d   = 1'b0;
      locked_d     = locked_q;
`ifdef TDM_DEMUX_PARITY_EN
      par_d        = par_q;
      par_err_d    = '0;
`endif
      if (en) begin
         if (fs) begin
            // fs always (re)starts a frame on this bit; it is only an error
            // when it lands anywhere but the expected frame start.
            sync_err_d = (state_q == RUN) && !frame_start;
            state_d    = RUN;
            locked_d   = 1'b1;
            bit_cnt_d  = BW'(1);
            slot_cnt_d = '0;
            sh_d       = {{(W - 1){1'b0}}, din};
`ifdef TDM_DEMUX_PARITY_EN
            par_d      = din;
`endif
         end else if (state_q == RUN) begin
            if (frame_start) begin
               // Missing frame sync: drop this bit and fall back to hunting.
               sync_err_d = 1'b1;
               state_d    = HUNT;
               locked_d   = 1'b0;
            end else begin
               bit_cnt_d = bit_cnt_q + 1'b1;
`ifdef TDM_DEMUX_PARITY_EN
               par_d = par_q ^ din;
               // The parity bit is not part of the word.
               if (bit_cnt_q < BW'(W)) begin
                  sh_d = {sh_q[W-2:0], din};
               end
`else
               sh_d = {sh_q[W-2:0], din};
`endif
               if (bit_last) begin
                  bit_cnt_d                    = '0;
                  ch_data_d[slot_cnt_q*W +: W] = sh_d;
                  ch_valid_d[slot_cnt_q]       = 1'b1;
`ifdef TDM_DEMUX_PARITY_EN
                  par_err_d[slot_cnt_q]        = par_q ^ din;
                  par_d                        = 1'b0;
`endif
                  if (slot_last) begin
                     slot_cnt_d   = '0;
                     frame_done_d = 1'b1;
                  end else begin
                     slot_cnt_d = slot_cnt_q + 1'b1;
                  end
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= HUNT;
         bit_cnt_q    <= '0;
         slot_cnt_q   <= '0;
         sh_q         <= '0;
         ch_data_q    <= '0;
         ch_valid_q   <= '0;
         frame_done_q <= 1'b0;
         sync_err_q   <= 1'b0;
         locked_q     <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
         par_q        <= 1'b0;
         par_err_q    <= '0;
`endif
      end else begin
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         slot_cnt_q   <= slot_cnt_d;
         sh_q         <= sh_d;
         ch_data_q    <= ch_data_d;
         ch_valid_q   <= ch_valid_d;
         frame_done_q <= frame_done_d;
         sync_err_q   <= sync_err_d;
         locked_q     <= locked_d;
`ifdef TDM_DEMUX_PARITY_EN
         par_q        <= par_d;
         par_err_q    <= par_err_d;
`endif
      end
   end

   assign ch_data    = ch_data_q;
   assign ch_valid   = ch_valid_q;
   assign frame_done = frame_done_q;
   assign sync_err   = sync_err_q;
   assign locked     = locked_q;
`ifdef TDM_DEMUX_PARITY_EN
   assign par_err    = par_err_q;
`else
   assign par_err    = '0;
`endif

endmodule

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux: self-checking bench for tdm_demux against a position-based frame model.
// Latency: every step drives one clock of stimulus and compares all outputs 1 ns after the edge.
// Backpressure: exercised through en stall cycles (fixed alternating and random).
module tb_tdm_demux;

   localparam int NCH = 4;
   localparam int W   = 8;
`ifdef TDM_DEMUX_PARITY_EN
   localparam int L = W + 1;
`else
   localparam int L = W;
`endif
   localparam int OW = NCH*W + 2*NCH + 3;

   typedef struct packed {
      logic en;
      logic din;
      logic fs;
   } cyc_t;

   logic             clk   = 1'b0;
   logic             rst_n = 1'b0;
   logic             en    = 1'b0;
   logic             din   = 1'b0;
   logic             fs    = 1'b0;
   logic [NCH*W-1:0] ch_data;
   logic [NCH-1:0]   ch_valid;
   logic             frame_done;
   logic             sync_err;
   logic [NCH-1:0]   par_err;
   logic             locked;

   int   n_cmp = 0;
   int   n_bad = 0;
   cyc_t stim[$];

   // Reference model: frame position (-1 = hunting), accumulated word, parity.
   int               m_pos;
   logic [31:0]      m_acc;
   logic             m_par;
   logic [NCH*W-1:0] m_data;
   logic [NCH-1:0]   m_valid;
   logic [NCH-1:0]   m_perr;
   logic             m_fd;
   logic             m_serr;
   logic             m_locked;

   tdm_demux #(.NCH(NCH), .W(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .din        (din),
      .fs         (fs),
      .ch_data    (ch_data),
      .ch_valid   (ch_valid),
      .frame_done (frame_done),
      .sync_err   (sync_err),
      .par_err    (par_err),
      .locked     (locked)
   );

   always #5 clk = ~clk;

   function automatic logic [OW-1:0] obs();
      return {ch_data, ch_valid, frame_done, sync_err, par_err, locked};
   endfunction

   function automatic logic [OW-1:0] expv();
      return {m_data, m_valid, m_fd, m_serr, m_perr, m_locked};
   endfunction

   task automatic model_reset();
      m_pos    = -1;
      m_acc    = '0;
      m_par    = 1'b0;
      m_data   = '0;
      m_valid  = '0;
      m_perr   = '0;
      m_fd     = 1'b0;
      m_serr   = 1'b0;
      m_locked = 1'b0;
   endtask

   // Drive one clock of stimulus and advance the model to the outputs expected after that edge.
   task automatic step(input cyc_t c);
      int b;
      int k;
      en      = c.en;
      din     = c.din;
      fs      = c.fs;
      m_valid = '0;
      m_perr  = '0;
      m_fd    = 1'b0;
      m_serr  = 1'b0;
      if (c.en) begin
         if (c.fs) begin
            if (m_pos > 0) m_serr = 1'b1;
            m_pos = 0;
            m_acc = '0;
            m_par = 1'b0;
         end else if (m_pos == 0) begin
            m_serr = 1'b1;
            m_pos  = -1;
         end
         if (m_pos >= 0) begin
            b = m_pos % L;
            k = m_pos / L;
            if (b < W) m_acc = m_acc * 2 + 32'(c.din);
            m_par = m_par ^ c.din;
            if (b == L - 1) begin
               m_data[k*W +: W] = m_acc[W-1:0];
               m_valid[k]       = 1'b1;
               m_fd             = (k == NCH - 1);
`ifdef TDM_DEMUX_PARITY_EN
               m_perr[k]        = m_par;
`endif
               m_acc = '0;
               m_par = 1'b0;
            end
            m_pos = (m_pos + 1) % (NCH * L);
         end
         m_locked = (m_pos >= 0);
      end
      @(posedge clk);
      #1;
   endtask

   // en_mode: 0 continuous, 1 one stall after every bit, 2 random stalls before each bit.
   task automatic add_frame(input logic [NCH*W-1:0] words, input bit with_fs, input int en_mode,
                            input logic [NCH-1:0] bad_par);
      cyc_t c;
      logic [W-1:0] w;
      for (int k = 0; k < NCH; k++) begin
         w = words[k*W +: W];
         for (int b = 0; b < L; b++) begin
            if (en_mode == 2) begin
               repeat ($urandom_range(0, 2)) stim.push_back({1'b0, 1'($urandom), 1'($urandom)});
            end
            c.en  = 1'b1;
            c.fs  = with_fs && (k == 0) && (b == 0);
            c.din = (b < W) ? w[W-1-b] : ((^w) ^ bad_par[k]);
            stim.push_back(c);
            if (en_mode == 1) stim.push_back({1'b0, 1'($urandom), 1'($urandom)});
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if (obs() !== '0) begin
         n_bad++;
         $display("FAIL reset_state: got %h want 0", obs());
      end
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      int v_idx[NCH];
      int fd_idx;
      fd_idx = -1;
      foreach (v_idx[k]) v_idx[k] = -1;
      // Hunt: bits without fs are ignored.
      repeat (5) stim.push_back({1'b1, 1'($urandom), 1'b0});
      add_frame(32'h01FF3CA5, 1'b1, 0, '0);
      foreach (stim[i]) begin
         step(stim[i]);
         n_cmp++;
         if (obs() !== expv()) begin
            n_bad++;
            $display("FAIL basic step %0d: got %h want %h", i, obs(), expv());
         end
         for (int k = 0; k < NCH; k++) if (ch_valid[k]) v_idx[k] = i;
         if (frame_done) fd_idx = i;
      end
      stim.delete();
      for (int k = 0; k < NCH; k++) begin
         n_cmp++;
         if (v_idx[k] != 5 + (k + 1) * L - 1) begin
            n_bad++;
            $display("FAIL basic_valid_time slot %0d: got %0d want %0d", k, v_idx[k], 5 + (k + 1) * L - 1);
         end
      end
      n_cmp++;
      if (fd_idx != 5 + NCH * L - 1) begin
         n_bad++;
         $display("FAIL basic_frame_done_time: got %0d want %0d", fd_idx, 5 + NCH * L - 1);
      end
      n_cmp++;
      if (ch_data !== 32'h01FF3CA5 || locked !== 1'b1) begin
         n_bad++;
         $display("FAIL basic_final: got data %h locked %b want 01ff3ca5 1", ch_data, locked);
      end
   endtask

   task automatic test_back_to_back();
      int n_serr;
      n_serr = 0;
      add_frame(32'h44332211, 1'b1, 0, '0);
      add_frame(32'h88776655, 1'b1, 0, '0);
      foreach (stim[i]) begin
         step(stim[i]);
         n_cmp++;
         if (obs() !== expv()) begin
            n_bad++;
            $display("FAIL back_to_back step %0d: got %h want %h", i, obs(), expv());
         end
         if (sync_err) n_serr++;
      end
      stim.delete();
      n_cmp++;
      if (ch_data !== 32'h88776655 || n_serr != 0) begin
         n_bad++;
         $display("FAIL back_to_back_final: got data %h sync_errs %0d want 88776655 0", ch_data, n_serr);
      end
   endtask

   task automatic test_missing_fs();
      int serr_idx;
      serr_idx = -1;
      add_frame(32'hC0DE1234, 1'b1, 0, '0);
      add_frame(32'h5A5A5A5A, 1'b0, 0, '0);
      foreach (stim[i]) begin
         step(stim[i]);
         n_cmp++;
         if (obs() !== expv()) begin
            n_bad++;
            $display("FAIL missing_fs step %0d: got %h want %h", i, obs(), expv());
         end
         if (sync_err && serr_idx < 0) serr_idx = i;
      end
      stim.delete();
      n_cmp++;
      if (serr_idx != NCH * L) begin
         n_bad++;
         $display("FAIL missing_fs_err_time: got %0d want %0d", serr_idx, NCH * L);
      end
      n_cmp++;
      if (ch_data !== 32'hC0DE1234 || locked !== 1'b0) begin
         n_bad++;
         $display("FAIL missing_fs_final: got data %h locked %b want c0de1234 0", ch_data, locked);
      end
   endtask

   task automatic test_midframe_fs();
      int serr_idx;
      int n_v1;
      serr_idx = -1;
      n_v1     = 0;
      add_frame(32'h99887766, 1'b1, 0, '0);
      while (stim.size() > L + 3) void'(stim.pop_back());
      add_frame(32'hDEADBEEF, 1'b1, 0, '0);
      foreach (stim[i]) begin
         step(stim[i]);
         n_cmp++;
         if (obs() !== expv()) begin
            n_bad++;
            $display("FAIL midframe_fs step %0d: got %h want %h", i, obs(), expv());
         end
         if (sync_err && serr_idx < 0) serr_idx = i;
         if (ch_valid[1]) n_v1++;
      end
      stim.delete();
      n_cmp++;
      if (serr_idx != L + 3 || n_v1 != 1) begin
         n_bad++;
         $display("FAIL midframe_fs_events: got err@%0d slot1_valids %0d want %0d 1", serr_idx, n_v1, L + 3);
      end
      n_cmp++;
      if (ch_data !== 32'hDEADBEEF || locked !== 1'b1) begin
         n_bad++;
         $display("FAIL midframe_fs_final: got data %h locked %b want deadbeef 1", ch_data, locked);
      end
   endtask

   task automatic test_enable();
      int fd_idx;
      fd_idx = -1;
      add_frame(32'h01FF3CA5, 1'b1, 1, '0);
      foreach (stim[i]) begin
         step(stim[i]);
         n_cmp++;
         if (obs() !== expv()) begin
            n_bad++;
            $display("FAIL enable step %0d: got %h want %h", i, obs(), expv());
         end
         if (frame_done) fd_idx = i;
      end
      stim.delete();
      n_cmp++;
      if (ch_data !== 32'h01FF3CA5 || fd_idx != 2 * NCH * L - 2) begin
         n_bad++;
         $display("FAIL enable_final: got data %h fd@%0d want 01ff3ca5 %0d", ch_data, fd_idx, 2 * NCH * L - 2);
      end
   endtask

`ifdef TDM_DEMUX_PARITY_EN
   task automatic test_parity();
      int perr0;
      perr0 = 0;
      add_frame(32'h01FF3CA5, 1'b1, 0, 4'b0001);
      foreach (stim[i]) begin
         step(stim[i]);
         n_cmp++;
         if (obs() !== expv()) begin
            n_bad++;
            $display("FAIL parity step %0d: got %h want %h", i, obs(), expv());
         end
         if (par_err[0] && ch_valid[0]) perr0++;
      end
      stim.delete();
      n_cmp++;
      if (perr0 != 1 || ch_data[7:0] !== 8'hA5) begin
         n_bad++;
         $display("FAIL parity_slot0: got perr %0d data %h want 1 a5", perr0, ch_data[7:0]);
      end
   endtask
`endif

   task automatic test_reset_midframe();
      add_frame(32'h13579BDF, 1'b1, 0, '0);
      for (int i = 0; i < 20; i++) begin
         step(stim[i]);
         n_cmp++;
         if (obs() !== expv()) begin
            n_bad++;
            $display("FAIL reset_mid step %0d: got %h want %h", i, obs(), expv());
         end
      end
      stim.delete();
      rst_n = 1'b0;
      #2;
      n_cmp++;
      if (obs() !== '0) begin
         n_bad++;
         $display("FAIL reset_mid_async: got %h want 0", obs());
      end
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      // Restart must hunt: bits without fs produce nothing.
      repeat (3) stim.push_back({1'b1, 1'($urandom), 1'b0});
      add_frame(32'h2468ACE0, 1'b1, 0, '0);
      foreach (stim[i]) begin
         step(stim[i]);
         n_cmp++;
         if (obs() !== expv()) begin
            n_bad++;
            $display("FAIL reset_restart step %0d: got %h want %h", i, obs(), expv());
         end
      end
      stim.delete();
   endtask

   task automatic test_random();
      cyc_t t;
      int   j;
      for (int f = 0; f < 12; f++) begin
         add_frame(NCH*W'($urandom), $urandom_range(0, 3) != 0, 2 * int'($urandom_range(0, 1)),
                   NCH'($urandom_range(0, 15)));
      end
      for (int g = 0; g < 4; g++) begin
         j = $urandom_range(0, stim.size() - 1);
         t = stim[j];
         t.fs = 1'b1;
         stim[j] = t;
      end
      foreach (stim[i]) begin
         step(stim[i]);
         n_cmp++;
         if (obs() !== expv()) begin
            n_bad++;
            $display("FAIL random step %0d: got %h want %h", i, obs(), expv());
         end
      end
      stim.delete();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_missing_fs();
      test_midframe_fs();
      test_enable();
`ifdef TDM_DEMUX_PARITY_EN
      test_parity();
`endif
      test_reset_midframe();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
